field_dump_tx: RTL and testbench

- Reads the current field RAM cell by cell (read-side counterpart of the config loader) and serialises it as a UART 8N1 byte stream for host capture or debug.
- Sits beside the field RAMs and takes the same write/read-port mux slot as the config loader.
- Top-level control grants a dump only while the simulation iterator is idle, the same way it grants loads.

---
 rtl/field_dump_tx.sv | 229 ++++++++++++++++++++++
 tb/tb_field_dump_tx.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/field_dump_tx.sv
// Field RAM dump: reads the field cell by cell and streams it as UART 8N1 (sync byte, then packed rows).
// Optional trailing XOR checksum byte when FIELD_DUMP_CHECKSUM_EN is defined.
module field_dump_tx #(
  parameter int unsigned FIELD_W      = 320,
  parameter int unsigned FIELD_H      = 240,
  parameter int unsigned CLKS_PER_BIT = 218,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_go,
  output logic                       o_busy,
  output logic                       o_rd_en,
  output logic [$clog2(FIELD_W)-1:0] o_cell_x_adr,
  output logic [$clog2(FIELD_H)-1:0] o_cell_y_adr,
  input  logic                       i_cell_state,
  output logic                       o_tx,
  output logic                       o_done
);

  localparam int unsigned XW = $clog2(FIELD_W);
  localparam int unsigned YW = $clog2(FIELD_H);
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);

  if ((FIELD_W % 8) != 0) begin : g_bad_width
    $error("FIELD_W must be a multiple of 8");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("CLKS_PER_BIT must be at least 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_FETCH,
    S_SEND,
    S_DONE
`ifdef FIELD_DUMP_CHECKSUM_EN
    , S_CSUM
`endif
  } state_t;

  state_t          state, state_nx;
  logic [7:0]      shreg, shreg_nx;
  logic [3:0]      bit_cnt, bit_nx;
  logic [CW-1:0]   clk_cnt, clk_nx;
  logic [3:0]      fcnt, fcnt_nx;
  logic [XW-1:0]   bx, bx_nx, x_nx;
  logic [YW-1:0]   by, by_nx, y_nx;
  logic            more, more_nx;
  logic            rd_nx, tx_nx, busy_nx, done_nx;
`ifdef FIELD_DUMP_CHECKSUM_EN
  logic [7:0]      csum, csum_nx;
  logic            csum_sent, csum_sent_nx;
`endif

  // Line level for frame position idx: start, 8 data bits LSB first, stop.
  function automatic logic frame_bit(input logic [3:0] idx, input logic [7:0] d);
    if (idx == 4'd0)      return 1'b0;
    else if (idx >= 4'd9) return 1'b1;
    else                  return d[3'(idx - 4'd1)];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      shreg        <= '0;
      bit_cnt      <= '0;
      clk_cnt      <= '0;
      fcnt         <= '0;
      bx           <= '0;
      by           <= '0;
      more         <= 1'b0;
      o_cell_x_adr <= '0;
      o_cell_y_adr <= '0;
      o_rd_en      <= 1'b0;
      o_tx         <= 1'b1;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
`ifdef FIELD_DUMP_CHECKSUM_EN
      csum         <= '0;
      csum_sent    <= 1'b0;
`endif
    end else begin
      state        <= state_nx;
      shreg        <= shreg_nx;
      bit_cnt      <= bit_nx;
      clk_cnt      <= clk_nx;
      fcnt         <= fcnt_nx;
      bx           <= bx_nx;
      by           <= by_nx;
      more         <= more_nx;
      o_cell_x_adr <= x_nx;
      o_cell_y_adr <= y_nx;
      o_rd_en      <= rd_nx;
      o_tx         <= tx_nx;
      o_busy       <= busy_nx;
      o_done       <= done_nx;
`ifdef FIELD_DUMP_CHECKSUM_EN
      csum         <= csum_nx;
      csum_sent    <= csum_sent_nx;
`endif
    end
  end

  // Next-state and next-output logic; outputs are registered so they line up with state.
  always_comb begin
    state_nx = state;
    shreg_nx = shreg;
    bit_nx   = bit_cnt;
    clk_nx   = clk_cnt;
    fcnt_nx  = fcnt;
    bx_nx    = bx;
    by_nx    = by;
    more_nx  = more;
    x_nx     = o_cell_x_adr;
    y_nx     = o_cell_y_adr;
    rd_nx    = 1'b0;
    tx_nx    = 1'b1;
    busy_nx  = 1'b1;
    done_nx  = 1'b0;
`ifdef FIELD_DUMP_CHECKSUM_EN
    csum_nx      = csum;
    csum_sent_nx = csum_sent;
`endif

    case (state)
      S_IDLE: begin
        busy_nx = i_go;
        if (i_go) state_nx = S_HDR;
      end

      S_HDR: begin
        shreg_nx = SYNC_BYTE;
        bx_nx    = '0;
        by_nx    = '0;
        more_nx  = 1'b1;
`ifdef FIELD_DUMP_CHECKSUM_EN
        csum_nx      = '0;
        csum_sent_nx = 1'b0;
`endif
        state_nx = S_SEND;
        bit_nx   = '0;
        clk_nx   = '0;
        tx_nx    = 1'b0;
      end

      // Reads go out in cycles 0..7, data returns in cycles 1..8 and shifts in from the MSB.
      S_FETCH: begin
        if (fcnt != 4'd0) shreg_nx = {i_cell_state, shreg[7:1]};
        if (fcnt < 4'd7) begin
          rd_nx = 1'b1;
          x_nx  = o_cell_x_adr + XW'(1);
        end
        if (fcnt == 4'd8) begin
          state_nx = S_SEND;
          bit_nx   = '0;
          clk_nx   = '0;
          tx_nx    = 1'b0;
`ifdef FIELD_DUMP_CHECKSUM_EN
          csum_nx  = csum ^ shreg_nx;
`endif
          if (bx == XW'(FIELD_W - 8)) begin
            bx_nx = '0;
            if (by == YW'(FIELD_H - 1)) more_nx = 1'b0;
            else                        by_nx   = by + YW'(1);
          end else begin
            bx_nx = bx + XW'(8);
          end
        end else begin
          fcnt_nx = fcnt + 4'd1;
        end
      end

      S_SEND: begin
        if (clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
          clk_nx = '0;
          if (bit_cnt == 4'd9) begin
            if (more) begin
              state_nx = S_FETCH;
              fcnt_nx  = '0;
              rd_nx    = 1'b1;
              x_nx     = bx;
              y_nx     = by;
            end
`ifdef FIELD_DUMP_CHECKSUM_EN
            else if (!csum_sent) begin
              state_nx = S_CSUM;
            end
`endif
            else begin
              state_nx = S_DONE;
              busy_nx  = 1'b0;
              done_nx  = 1'b1;
            end
          end else begin
            bit_nx = bit_cnt + 4'd1;
            tx_nx  = frame_bit(bit_nx, shreg);
          end
        end else begin
          clk_nx = clk_cnt + CW'(1);
          tx_nx  = frame_bit(bit_cnt, shreg);
        end
      end

`ifdef FIELD_DUMP_CHECKSUM_EN
      S_CSUM: begin
        shreg_nx     = csum;
        csum_sent_nx = 1'b1;
        state_nx     = S_SEND;
        bit_nx       = '0;
        clk_nx       = '0;
        tx_nx        = 1'b0;
      end
`endif

      S_DONE: begin
        busy_nx  = 1'b0;
        state_nx = S_IDLE;
      end

      default: begin
        busy_nx  = 1'b0;
        state_nx = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_field_dump_tx.sv
// Scoreboard bench for field_dump_tx: a UART decoder and read-port monitor pop expected
// bytes/addresses produced by a row-major packing model of a small random field.
module tb_field_dump_tx;

  localparam int unsigned FW  = 16;
  localparam int unsigned FH  = 2;
  localparam int unsigned CPB = 4;
  localparam int unsigned XW  = $clog2(FW);
  localparam int unsigned YW  = $clog2(FH);
  localparam int NB = FW * FH / 8;
`ifdef FIELD_DUMP_CHECKSUM_EN
  localparam int NFR = NB + 2;
`else
  localparam int NFR = NB + 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_go = 1'b0;
  logic          i_cell_state = 1'b0;
  logic          o_busy, o_rd_en, o_tx, o_done;
  logic [XW-1:0] o_cell_x_adr;
  logic [YW-1:0] o_cell_y_adr;

  field_dump_tx #(
    .FIELD_W(FW), .FIELD_H(FH), .CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_go(i_go), .o_busy(o_busy), .o_rd_en(o_rd_en),
    .o_cell_x_adr(o_cell_x_adr), .o_cell_y_adr(o_cell_y_adr),
    .i_cell_state(i_cell_state), .o_tx(o_tx), .o_done(o_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic fld [0:FH-1][0:FW-1];
  logic [7:0] exp_bytes[$];
  int exp_adr[$];

  int cyc = 0, last_rd = -100, rd_run = 0, done_cnt = 0, frames = 0;
  logic prev_done = 1'b0;
  logic mon_act = 1'b0, mon_v = 1'b0, mon_glitch = 1'b0;
  int mon_bit = 0, mon_c = 0;
  logic [7:0] mon_byte = 8'h00;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Synchronous field RAM: data valid the cycle after the read strobe, junk otherwise.
  always @(posedge clk)
    i_cell_state <= o_rd_en ? fld[o_cell_y_adr][o_cell_x_adr] : 1'($urandom);

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_act   = 1'b0;
      rd_run    = 0;
      prev_done = 1'b0;
    end else begin
      cyc++;
      if (o_rd_en) begin
        chk("rd_before_header_done", int'(frames > 0), 1);
        if (exp_adr.size() == 0) fail("rd_unexpected");
        else begin
          int a;
          a = exp_adr.pop_front();
          chk("rd_x", int'(o_cell_x_adr), a % 65536);
          chk("rd_y", int'(o_cell_y_adr), a / 65536);
        end
        rd_run++;
        last_rd = cyc;
      end else if (rd_run != 0) begin
        chk("rd_burst_len", rd_run, 8);
        rd_run = 0;
      end
      if (o_done) begin
        done_cnt++;
        chk("done_single_cycle", int'(prev_done), 0);
        chk("busy_low_at_done", int'(o_busy), 0);
        chk("frames_at_done", frames, NFR);
      end
      prev_done = o_done;

      if (!mon_act) begin
        if (o_tx == 1'b0) begin
          mon_act = 1'b1; mon_bit = 0; mon_c = 1; mon_v = 1'b0;
          mon_glitch = 1'b0; mon_byte = 8'h00;
          chk("busy_in_frame", int'(o_busy), 1);
          if (frames >= 1 && frames <= NB) chk("start_after_capture", cyc - last_rd, 2);
        end
      end else begin
        if (mon_c == 0) begin
          mon_v = o_tx;
          if (mon_bit >= 1 && mon_bit <= 8) mon_byte[mon_bit-1] = o_tx;
          else if (mon_bit == 9 && o_tx != 1'b1) mon_glitch = 1'b1;
        end else if (o_tx != mon_v) begin
          mon_glitch = 1'b1;
        end
        mon_c++;
        if (mon_c == CPB) begin
          mon_c = 0;
          mon_bit++;
          if (mon_bit == 10) begin
            chk("bit_timing", int'(mon_glitch), 0);
            if (exp_bytes.size() == 0) fail("byte_unexpected");
            else chk("uart_byte", int'(mon_byte), int'(exp_bytes.pop_front()));
            frames++;
            mon_act = 1'b0;
          end
        end
      end
    end
  end

  // Row-major read order: byte k covers linear cells 8k..8k+7, LSB = lowest x.
  task automatic push_adrs();
    for (int idx = 0; idx < FW * FH; idx++)
      exp_adr.push_back((idx / FW) * 65536 + (idx % FW));
  endtask

  task automatic build_expected();
    logic [7:0] b, xs;
    xs = 8'h00;
    exp_bytes.push_back(8'hA5);
    for (int k = 0; k < NB; k++) begin
      b = 8'h00;
      for (int i = 0; i < 8; i++) b[i] = fld[(k*8+i) / FW][(k*8+i) % FW];
      xs ^= b;
      exp_bytes.push_back(b);
    end
`ifdef FIELD_DUMP_CHECKSUM_EN
    exp_bytes.push_back(xs);
`endif
    push_adrs();
  endtask

  task automatic fill(input int mode);
    for (int y = 0; y < FH; y++)
      for (int x = 0; x < FW; x++)
        fld[y][x] = (mode == 0) ? 1'b0 : 1'($urandom);
  endtask

  task automatic run_dump(input bit spam);
    int start_done, budget, n;
    start_done = done_cnt;
    budget = NFR * (10 * CPB + 12) + 50;
    frames = 0;
    @(negedge clk); i_go = 1'b1;
    @(negedge clk); i_go = 1'b0;
    for (n = 0; n < budget; n++) begin
      @(negedge clk);
      if (o_done) begin
        if (spam) i_go = 1'b1;
        break;
      end
      i_go = spam ? ($urandom_range(0, 4) == 0) : 1'b0;
    end
    if (n == budget) fail("done_timeout");
    @(negedge clk); i_go = 1'b0;
    repeat (30 * CPB) @(negedge clk);
    chk("busy_after_done", int'(o_busy), 0);
    chk("done_count", done_cnt - start_done, 1);
    chk("bytes_left", exp_bytes.size(), 0);
    chk("adr_left", exp_adr.size(), 0);
    exp_bytes.delete();
    exp_adr.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    fill(0);
    repeat (3) @(negedge clk);
    chk("rst_tx", int'(o_tx), 1);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_done", int'(o_done), 0);
    chk("rst_rd_en", int'(o_rd_en), 0);
    chk("rst_x", int'(o_cell_x_adr), 0);
    chk("rst_y", int'(o_cell_y_adr), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_tx", int'(o_tx), 1);

    // All cells dead.
    fill(0);
    build_expected();
    run_dump(1'b0);

    // Sparse pattern with hand-derived bytes.
    fill(0);
    fld[0][0] = 1'b1; fld[0][9] = 1'b1; fld[1][15] = 1'b1;
    exp_bytes.push_back(8'hA5); exp_bytes.push_back(8'h01); exp_bytes.push_back(8'h02);
    exp_bytes.push_back(8'h00); exp_bytes.push_back(8'h80);
`ifdef FIELD_DUMP_CHECKSUM_EN
    exp_bytes.push_back(8'h83);
`endif
    push_adrs();
    run_dump(1'b0);

    // i_go while busy and coincident with o_done.
    fill(1);
    build_expected();
    run_dump(1'b1);

    // Asynchronous reset in the middle of a data bit.
    fill(0);
    build_expected();
    frames = 0;
    @(negedge clk); i_go = 1'b1;
    @(negedge clk); i_go = 1'b0;
    for (n = 0; n < 400; n++) begin
      @(negedge clk);
      if (frames >= 1 && mon_act && mon_bit >= 1 && mon_bit <= 8 && o_tx == 1'b0) break;
    end
    if (n == 400) fail("wait_data_bit_timeout");
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_tx", int'(o_tx), 1);
    chk("async_rst_busy", int'(o_busy), 0);
    chk("async_rst_rd_en", int'(o_rd_en), 0);
    exp_bytes.delete();
    exp_adr.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    fill(1);
    build_expected();
    run_dump(1'b0);

    // Random fields.
    for (int t = 0; t < 6; t++) begin
      fill(1);
      build_expected();
      run_dump(1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
